vend_controller: RTL and testbench
==================================

# vend_controller

Sequencing controller for the vending datapath. It accumulates coin credit in Rs 5 units and holds a programmable per-item price table. It arbitrates among coin, selection and cancel events, runs a dispense request/done handshake with the product mechanism (with a timeout), and pays change or refunds as a train of `change_5` pulses. It sits between the coin acceptor and the dispense mechanism and replaces the fixed-price single-product FSM.

## Interface
Parameters:
- `NUM_ITEMS`, default 4: number of selectable products.
- `ITEM_W`, default 2: width of the item index; must satisfy clog2(NUM_ITEMS).
- `CREDIT_W`, default 4: width of the credit and price fields, in Rs 5 units.
- `MAX_CREDIT`, default 8: credit ceiling in units (Rs 40); must be < 2^CREDIT_W.
- `TIMEOUT`, default 16: number of VEND cycles without `dispense_done` before the vend is aborted.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `coin_5`  in  1  one-cycle pulse; adds 1 unit.
- `coin_10`  in  1  one-cycle pulse; adds 2 units.
- `sel_valid`  in  1  one-cycle selection strobe.
- `sel_item`  in  ITEM_W  selected item; qualified by `sel_valid`.
- `cancel`  in  1  one-cycle refund request.
- `dispense_done`  in  1  mechanism has delivered the item.
- `cfg_we`  in  1  price write strobe.
- `cfg_item`  in  ITEM_W  price table index.
- `cfg_price`  in  CREDIT_W  price in units; 0 means the item is disabled.
- `dispense_req`  out  1  level; held high until done or timeout.
- `dispense_item`  out  ITEM_W  latched item; valid while `dispense_req` is high.
- `change_5`  out  1  one-cycle pulse per Rs 5 returned.
- `coin_reject`  out  1  one-cycle pulse; the coin was not credited.
- `vend_fail`  out  1  one-cycle pulse; the selection was refused or the vend timed out.
- `credit`  out  CREDIT_W  current credit in units.
- `busy`  out  1  high in VEND and CHANGE.

## Operation
- States: ACCEPT, VEND, CHANGE. The state encoding lives in the shared package.
- Reset values: state ACCEPT; `credit` 0; all prices 0; timeout counter 0; every output 0.

ACCEPT
- Event priority within one cycle: `cancel` > `sel_valid` > coin.
- A coin that loses arbitration is rejected with `coin_reject`.
- `coin_5` and `coin_10` in the same cycle: both coins rejected, no credit added.
- Coin acceptance: if credit + value ≤ MAX_CREDIT, credit += value. Otherwise `coin_reject` and credit unchanged.
- `cancel`: with credit > 0, go to CHANGE. With credit 0, no effect.
- `sel_valid`: read p = price[sel_item].
  - p == 0 or credit < p: `vend_fail`, stay in ACCEPT, credit unchanged.
  - Otherwise: credit -= p, latch the item and p, clear the timeout counter, go to VEND.

VEND
- `dispense_req` = 1 and `dispense_item` = latched item.
- `dispense_done` high: go to CHANGE if credit > 0, else go to ACCEPT.
- Timeout counter reaches TIMEOUT first: `vend_fail`, credit += latched p (full refund), go to CHANGE.
- `dispense_done` and timeout in the same cycle: `dispense_done` wins.
- Coins, `sel_valid` and `cancel` are ignored. Coins additionally pulse `coin_reject`.

CHANGE
- `change_5` alternates high, low, high, …, starting in the first CHANGE cycle.
- Each high cycle decrements credit by 1.
- Exit to ACCEPT on the cycle after the pulse that brings credit to 0.
- Coins are rejected; `sel_valid` and `cancel` are ignored.

Configuration
- `cfg_we` is accepted in any state and takes effect the next cycle.
- An in-flight vend uses the latched p, never the live table entry.
- `cfg_we` and `sel_valid` to the same item in the same cycle: the selection sees the old price.

Arithmetic
- All credit arithmetic is unsigned and CREDIT_W+1 wide internally, so the MAX_CREDIT check cannot wrap.

## Timing
- All outputs are registered.
- Input events at cycle t produce effects (credit, `coin_reject`, `vend_fail`, `dispense_req`) at t+1.
- `dispense_done` sampled high at t drops `dispense_req` at t+1.
- Timeout: `dispense_req` rises at t; with no `dispense_done`, `vend_fail` pulses at t+TIMEOUT and `dispense_req` is low from then on.
- Change of N units: pulses at c, c+2, …, c+2(N−1), where c is the first CHANGE cycle. ACCEPT is entered at c+2N−1.
- `reset` asserted in any state, including mid-VEND and mid-CHANGE: all state and outputs are cleared at the next edge, and no pending change is paid.
- `busy` = 1 exactly while in VEND or CHANGE.

## Structure
- `vend_pkg`: state enum, coin unit constants (COIN5_UNITS=1, COIN10_UNITS=2), and a `price_t` typedef of CREDIT_W bits.
- Sub-module `vend_price_table`:
  - NUM_ITEMS×CREDIT_W register file.
  - Synchronous write, combinational read.
  - Cleared by `reset`.
- The top level holds the FSM, the credit register, the latched item and price, the timeout counter, and the change pulse toggle.

## Test plan
- Price item 1 = 3. Sequence `coin_10`, `coin_5`, then `sel_item`=1 → `dispense_req`=1, `dispense_item`=1. `dispense_done` 4 cycles later → back to ACCEPT, credit 0, no `change_5`.
- Price item 2 = 2. Insert two `coin_10` (credit 4), select item 2, then `dispense_done` → exactly 2 `change_5` pulses 2 cycles apart, then ACCEPT with credit 0.
- Credit 1, price 3, `sel_valid` → `vend_fail` one cycle, credit stays 1. Selecting an unpriced item (price 0) → `vend_fail`.
- TIMEOUT=16, valid selection with price 2 from credit 3, no `dispense_done` → `vend_fail` 16 cycles after `dispense_req` rises, then 3 `change_5` pulses.
- Credit 7 plus `coin_10` → `coin_reject`, credit stays 7. `coin_5` during VEND → `coin_reject`. `coin_5` with `coin_10` in the same cycle → reject, credit unchanged. `cancel` with `coin_5` in the same cycle at credit 2 → 2 refund pulses plus `coin_reject`.
- `reset` during the second CHANGE cycle of a 3-unit refund → next cycle credit 0, state ACCEPT, no further `change_5` pulses, all prices 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencing controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam int COIN5_UNITS  = 1;
    localparam int COIN10_UNITS = 2;
    localparam int PRICE_W      = 4;

    typedef logic [PRICE_W-1:0] price_t;

endpackage

// File: rtl/vend_price_table.sv
// Per-item price register file.
// Synchronous write, combinational read, cleared on reset.
module vend_price_table #(
    parameter int NUM_ITEMS = 4,
    parameter int ITEM_W    = 2,
    parameter int CREDIT_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ITEM_W-1:0]   wr_item,
    input  logic [CREDIT_W-1:0] wr_price,
    input  logic [ITEM_W-1:0]   rd_item,
    output logic [CREDIT_W-1:0] rd_price
);

    logic [CREDIT_W-1:0] mem [NUM_ITEMS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(wr_item) < NUM_ITEMS)) begin
            mem[wr_item] <= wr_price;
        end
    end

    // Indices beyond the table read as disabled items.
    always_comb begin
        rd_price = '0;
        if (int'(rd_item) < NUM_ITEMS) begin
            rd_price = mem[rd_item];
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, priced selection,
// dispense handshake with timeout, and pulsed change/refund.
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int ITEM_W     = 2,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel_item,
    input  logic                cancel,
    input  logic                dispense_done,
    input  logic                cfg_we,
    input  logic [ITEM_W-1:0]   cfg_item,
    input  logic [CREDIT_W-1:0] cfg_price,
    output logic                dispense_req,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                change_5,
    output logic                coin_reject,
    output logic                vend_fail,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state_q, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [ITEM_W-1:0]   item_n;
    logic [CREDIT_W-1:0] lprice_q, lprice_n;
    logic [TW-1:0]       tcnt_q, tcnt_n;
    logic                chg_n, rej_n, fail_n;
    logic                req_n, busy_n;

    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W:0]   coin_units;
    logic [CREDIT_W:0]   coin_sum;
    logic                any_coin;

    vend_price_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_W    (ITEM_W),
        .CREDIT_W  (CREDIT_W)
    ) u_prices (
        .clk      (clk),
        .reset    (reset),
        .we       (cfg_we),
        .wr_item  (cfg_item),
        .wr_price (cfg_price),
        .rd_item  (sel_item),
        .rd_price (sel_price)
    );

    // One bit of headroom keeps the ceiling compare from wrapping.
    assign any_coin   = coin_5 | coin_10;
    assign coin_units = coin_10 ? (CREDIT_W+1)'(COIN10_UNITS)
                                : (CREDIT_W+1)'(COIN5_UNITS);
    assign coin_sum   = {1'b0, credit} + coin_units;

    always_comb begin
        state_n  = state_q;
        credit_n = credit;
        item_n   = dispense_item;
        lprice_n = lprice_q;
        tcnt_n   = tcnt_q;
        chg_n    = 1'b0;
        rej_n    = 1'b0;
        fail_n   = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                if (cancel) begin
                    rej_n = any_coin;
                    if (credit != '0) begin
                        state_n = ST_CHANGE;
                        chg_n   = 1'b1;
                    end
                end else if (sel_valid) begin
                    rej_n = any_coin;
                    if ((sel_price == '0) || (credit < sel_price)) begin
                        fail_n = 1'b1;
                    end else begin
                        credit_n = credit - sel_price;
                        item_n   = sel_item;
                        lprice_n = sel_price;
                        tcnt_n   = '0;
                        state_n  = ST_VEND;
                    end
                end else if (coin_5 && coin_10) begin
                    rej_n = 1'b1;
                end else if (any_coin) begin
                    if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                        credit_n = coin_sum[CREDIT_W-1:0];
                    end else begin
                        rej_n = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                rej_n  = any_coin;
                tcnt_n = tcnt_q + TW'(1);
                if (dispense_done) begin
                    chg_n   = (credit != '0);
                    state_n = (credit != '0) ? ST_CHANGE : ST_ACCEPT;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    fail_n   = 1'b1;
                    credit_n = credit + lprice_q;
                    chg_n    = 1'b1;
                    state_n  = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                rej_n = any_coin;
                if (change_5) begin
                    credit_n = credit - CREDIT_W'(1);
                    if (credit == CREDIT_W'(1)) begin
                        state_n = ST_ACCEPT;
                    end
                end else begin
                    chg_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_ACCEPT;
            end
        endcase
        req_n  = (state_n == ST_VEND);
        busy_n = (state_n != ST_ACCEPT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ACCEPT;
            credit        <= '0;
            dispense_item <= '0;
            lprice_q      <= '0;
            tcnt_q        <= '0;
            change_5      <= 1'b0;
            coin_reject   <= 1'b0;
            vend_fail     <= 1'b0;
            dispense_req  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_n;
            credit        <= credit_n;
            dispense_item <= item_n;
            lprice_q      <= lprice_n;
            tcnt_q        <= tcnt_n;
            change_5      <= chg_n;
            coin_reject   <= rej_n;
            vend_fail     <= fail_n;
            dispense_req  <= req_n;
            busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed and randomized bench for vend_controller against a
// queue-based behavioural model of credit, vending and change.
module tb_vend_controller;

    localparam int NI   = 4;
    localparam int IW   = 2;
    localparam int CW   = 4;
    localparam int MAXC = 8;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          coin_5 = 1'b0;
    logic          coin_10 = 1'b0;
    logic          sel_valid = 1'b0;
    logic [IW-1:0] sel_item = '0;
    logic          cancel = 1'b0;
    logic          dispense_done = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_item = '0;
    logic [CW-1:0] cfg_price = '0;
    logic          dispense_req;
    logic [IW-1:0] dispense_item;
    logic          change_5;
    logic          coin_reject;
    logic          vend_fail;
    logic [CW-1:0] credit;
    logic          busy;

    vend_controller #(
        .NUM_ITEMS  (NI),
        .ITEM_W     (IW),
        .CREDIT_W   (CW),
        .MAX_CREDIT (MAXC),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_5        (coin_5),
        .coin_10       (coin_10),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .dispense_done (dispense_done),
        .cfg_we        (cfg_we),
        .cfg_item      (cfg_item),
        .cfg_price     (cfg_price),
        .dispense_req  (dispense_req),
        .dispense_item (dispense_item),
        .change_5      (change_5),
        .coin_reject   (coin_reject),
        .vend_fail     (vend_fail),
        .credit        (credit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Model: credit as an integer, a vending flag with elapsed
    // cycles, and the pending change train as a queue of pulse bits.
    int m_credit = 0;
    int m_price[NI];
    bit m_vend = 1'b0;
    int m_vcyc = 0;
    int m_item = 0;
    int m_p = 0;
    bit pay_q[$];
    bit e_rej = 1'b0;
    bit e_fail = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_pay(input int n);
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(1'b1);
            if (i < n - 1) pay_q.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        bit coin;
        int val;
        int p;
        coin = coin_5 | coin_10;
        e_rej = 1'b0;
        e_fail = 1'b0;
        if (reset) begin
            m_credit = 0;
            for (int i = 0; i < NI; i++) m_price[i] = 0;
            m_vend = 1'b0;
            m_vcyc = 0;
            m_item = 0;
            m_p = 0;
            pay_q.delete();
            return;
        end
        if (pay_q.size() > 0) begin
            if (pay_q[0]) m_credit--;
            void'(pay_q.pop_front());
            e_rej = coin;
        end else if (m_vend) begin
            e_rej = coin;
            m_vcyc++;
            if (dispense_done) begin
                m_vend = 1'b0;
                start_pay(m_credit);
            end else if (m_vcyc == TO) begin
                m_vend = 1'b0;
                e_fail = 1'b1;
                m_credit += m_p;
                start_pay(m_credit);
            end
        end else if (cancel) begin
            e_rej = coin;
            start_pay(m_credit);
        end else if (sel_valid) begin
            e_rej = coin;
            p = m_price[sel_item];
            if (p == 0 || m_credit < p) begin
                e_fail = 1'b1;
            end else begin
                m_credit -= p;
                m_item = int'(sel_item);
                m_p = p;
                m_vend = 1'b1;
                m_vcyc = 0;
            end
        end else if (coin_5 && coin_10) begin
            e_rej = 1'b1;
        end else if (coin) begin
            val = coin_10 ? 2 : 1;
            if (m_credit + val <= MAXC) m_credit += val;
            else e_rej = 1'b1;
        end
        if (cfg_we) m_price[cfg_item] = int'(cfg_price);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("credit", 32'(credit), 32'(m_credit));
        check("busy", 32'(busy), 32'(m_vend || pay_q.size() > 0));
        check("dispense_req", 32'(dispense_req), 32'(m_vend));
        if (m_vend) check("dispense_item", 32'(dispense_item), 32'(m_item));
        check("change_5", 32'(change_5),
              (pay_q.size() > 0) ? 32'(pay_q[0]) : 32'd0);
        check("coin_reject", 32'(coin_reject), 32'(e_rej));
        check("vend_fail", 32'(vend_fail), 32'(e_fail));
        reset = 1'b0;
        coin_5 = 1'b0;
        coin_10 = 1'b0;
        sel_valid = 1'b0;
        cancel = 1'b0;
        dispense_done = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic put_coin(input bit ten);
        if (ten) coin_10 = 1'b1;
        else coin_5 = 1'b1;
        cyc();
    endtask

    task automatic select(input int item);
        sel_valid = 1'b1;
        sel_item = IW'(item);
        cyc();
    endtask

    task automatic set_price(input int item, input int price);
        cfg_we = 1'b1;
        cfg_item = IW'(item);
        cfg_price = CW'(price);
        cyc();
    endtask

    // Runs until idle; counts pulses including the current cycle.
    task automatic run_out(output int n);
        int k;
        n = int'(change_5);
        k = 0;
        while (busy && k < 100) begin
            cyc();
            if (change_5) n++;
            k++;
        end
        check("idle_bound", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        for (int i = 0; i < NI; i++) m_price[i] = 0;

        reset = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        check("rst_credit", 32'(credit), 32'd0);

        set_price(1, 3);
        set_price(2, 2);

        put_coin(1'b1);
        put_coin(1'b0);
        check("credit_3", 32'(credit), 32'd3);
        select(1);
        check("req_item1", 32'(dispense_req), 32'd1);
        check("item1", 32'(dispense_item), 32'd1);
        cyc();
        cyc();
        cyc();
        dispense_done = 1'b1;
        cyc();
        run_out(n);
        check("exact_pay_pulses", 32'(n), 32'd0);
        check("exact_pay_credit", 32'(credit), 32'd0);

        put_coin(1'b1);
        put_coin(1'b1);
        sel_valid = 1'b1;
        sel_item = 2'd2;
        cfg_we = 1'b1;
        cfg_item = 2'd2;
        cfg_price = 4'd5;
        cyc();
        check("old_price_credit", 32'(credit), 32'd2);
        cyc();
        dispense_done = 1'b1;
        cyc();
        run_out(n);
        check("change_pulses_2", 32'(n), 32'd2);
        set_price(2, 2);

        put_coin(1'b0);
        select(1);
        check("short_fail", 32'(vend_fail), 32'd1);
        check("short_credit", 32'(credit), 32'd1);
        select(0);
        check("unpriced_fail", 32'(vend_fail), 32'd1);
        cancel = 1'b1;
        cyc();
        run_out(n);
        check("refund_1", 32'(n), 32'd1);

        put_coin(1'b1);
        put_coin(1'b0);
        select(2);
        check("to_req", 32'(dispense_req), 32'd1);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!vend_fail && k < 40);
        check("timeout_latency", 32'(k), 32'(TO));
        check("timeout_req_low", 32'(dispense_req), 32'd0);
        run_out(n);
        check("timeout_refund", 32'(n), 32'd3);

        put_coin(1'b1);
        put_coin(1'b1);
        put_coin(1'b1);
        put_coin(1'b0);
        put_coin(1'b1);
        check("ceiling_reject", 32'(coin_reject), 32'd1);
        check("ceiling_credit", 32'(credit), 32'd7);
        select(1);
        put_coin(1'b0);
        check("vend_coin_reject", 32'(coin_reject), 32'd1);
        dispense_done = 1'b1;
        cyc();
        run_out(n);
        check("change_4", 32'(n), 32'd4);
        put_coin(1'b1);
        coin_5 = 1'b1;
        coin_10 = 1'b1;
        cyc();
        check("dual_reject", 32'(coin_reject), 32'd1);
        check("dual_credit", 32'(credit), 32'd2);
        cancel = 1'b1;
        coin_5 = 1'b1;
        cyc();
        check("cancel_coin_rej", 32'(coin_reject), 32'd1);
        run_out(n);
        check("cancel_refund_2", 32'(n), 32'd2);

        put_coin(1'b1);
        put_coin(1'b0);
        cancel = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("mid_rst_credit", 32'(credit), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) cyc();
        put_coin(1'b1);
        select(1);
        check("rst_price_cleared", 32'(vend_fail), 32'd1);

        for (int i = 0; i < NI; i++) set_price(i, $urandom_range(0, 5));
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            coin_5 = ($urandom_range(0, 99) < 25);
            coin_10 = ($urandom_range(0, 99) < 20);
            sel_valid = ($urandom_range(0, 99) < 12);
            sel_item = IW'($urandom_range(0, NI - 1));
            cancel = ($urandom_range(0, 99) < 4);
            dispense_done = ($urandom_range(0, 99) < 8);
            cfg_we = ($urandom_range(0, 99) < 5);
            cfg_item = IW'($urandom_range(0, NI - 1));
            cfg_price = CW'($urandom_range(0, 6));
            cyc();
        end
        run_out(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
